// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module   : nibble_serial_adder
// Function : W-bit adder built from one external 4-bit adder, one nibble/cycle
// Revision : 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   In_valid,
  output logic                   In_ready,
  input  logic [0:4*NIBBLES-1]   In_A,
  input  logic [0:4*NIBBLES-1]   In_B,
  input  logic                   In_Ci,
  output logic [0:3]             Add_A,
  output logic [0:3]             Add_B,
  output logic                   Add_Ci,
  input  logic [0:3]             Add_S,
  input  logic                   Add_Co,
  output logic                   Out_valid,
  input  logic                   Out_ready,
  output logic [0:4*NIBBLES-1]   Out_S,
  output logic                   Out_Co,
  output logic                   Out_Ovf,
  output logic                   Busy
);

  localparam int              W      = 4 * NIBBLES;
  localparam int              KW     = $clog2(NIBBLES);
  localparam logic [KW-1:0]   K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      s_nib;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  // Select the active nibble with constant slices; k only ever spans 0..NIBBLES-1.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (k_q == KW'(n)) begin
        a_nib = a_q[4*n +: 4];
        b_nib = b_q[4*n +: 4];
      end
    end
    for (int i = 0; i < 4; i++) begin
      s_nib[i] = Add_S[i];
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (In_valid) begin
          for (int i = 0; i < W; i++) begin
            a_d[i] = In_A[i];
            b_d[i] = In_B[i];
          end
          carry_d = In_Ci;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (k_q == KW'(n)) begin
            sum_d[4*n +: 4] = s_nib;
          end
        end
        carry_d = Add_Co;
        // k parks on the last nibble instead of wrapping; it is reloaded on accept.
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (Out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      Add_A[i] = (state_q == RUN) ? a_nib[i] : 1'b0;
      Add_B[i] = (state_q == RUN) ? b_nib[i] : 1'b0;
    end
    Add_Ci = (state_q == RUN) ? carry_q : 1'b0;
    for (int i = 0; i < W; i++) begin
      Out_S[i] = sum_q[i];
    end
  end

  assign In_ready  = (state_q == IDLE);
  assign Out_valid = (state_q == DONE);
  assign Busy      = (state_q != IDLE);
  assign Out_Co    = carry_q;
  assign Out_Ovf   = (a_q[W-1] ~^ b_q[W-1]) & (a_q[W-1] ^ sum_q[W-1]);

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module   : tb_nibble_serial_adder
// Function : directed + random operations against an arithmetic reference
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic           Clk = 1'b0;
  logic           Rst_n;
  logic           In_valid;
  logic           In_ready;
  logic [0:W-1]   In_A;
  logic [0:W-1]   In_B;
  logic           In_Ci;
  logic [0:3]     Add_A;
  logic [0:3]     Add_B;
  logic           Add_Ci;
  logic [0:3]     Add_S;
  logic           Add_Co;
  logic           Out_valid;
  logic           Out_ready;
  logic [0:W-1]   Out_S;
  logic           Out_Co;
  logic           Out_Ovf;
  logic           Busy;

  int n_chk  = 0;
  int n_pass = 0;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .In_A      (In_A),
    .In_B      (In_B),
    .In_Ci     (In_Ci),
    .Add_A     (Add_A),
    .Add_B     (Add_B),
    .Add_Ci    (Add_Ci),
    .Add_S     (Add_S),
    .Add_Co    (Add_Co),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Out_S     (Out_S),
    .Out_Co    (Out_Co),
    .Out_Ovf   (Out_Ovf),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  // External 4-bit adder.
  logic [3:0] ext_a, ext_b;
  logic [4:0] ext_t;
  always_comb begin
    ext_a = '0;
    ext_b = '0;
    for (int i = 0; i < 4; i++) begin
      ext_a[i] = Add_A[i];
      ext_b[i] = Add_B[i];
    end
    ext_t = {1'b0, ext_a} + {1'b0, ext_b} + {4'd0, Add_Ci};
    for (int i = 0; i < 4; i++) begin
      Add_S[i] = ext_t[i];
    end
    Add_Co = ext_t[4];
  end

  function automatic logic [0:W-1] to_asc(input logic [W-1:0] x);
    logic [0:W-1] r;
    for (int i = 0; i < W; i++) r[i] = x[i];
    return r;
  endfunction

  function automatic logic [W-1:0] from_asc(input logic [0:W-1] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[i];
    return r;
  endfunction

  function automatic logic [3:0] nib(input logic [0:3] x);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = x[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input int hold, input logic chk_all);
    int           waits;
    int unsigned  m;
    logic [W:0]   full;
    logic         ovf;
    waits = 0;
    while (In_ready !== 1'b1 && waits < 20) begin
      @(negedge Clk);
      waits++;
    end
    check("in_ready_before_op", In_ready, 1);
    In_valid = 1'b1;
    In_A     = to_asc(a);
    In_B     = to_asc(b);
    In_Ci    = ci;
    for (int k = 0; k < NIBBLES; k++) begin
      @(negedge Clk);
      m = 32'd1 << (4 * k);
      check("run_add_a", nib(Add_A), (a >> (4 * k)) & 16'hF);
      check("run_add_b", nib(Add_B), (b >> (4 * k)) & 16'hF);
      check("run_add_ci", Add_Ci, ((a % m) + (b % m) + ci) / m);
      check("run_out_valid", Out_valid, 0);
      if (chk_all) begin
        check("run_busy", Busy, 1);
        check("run_in_ready", In_ready, 0);
      end
      // Garbage on inputs during RUN must not matter.
      In_valid = 1'($urandom);
      In_A     = to_asc(W'($urandom));
      In_B     = to_asc(W'($urandom));
      In_Ci    = 1'($urandom);
    end
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    @(negedge Clk);
    for (int h = 0; h <= hold; h++) begin
      check("done_out_valid", Out_valid, 1);
      check("done_out_s", from_asc(Out_S), full[W-1:0]);
      check("done_out_co", Out_Co, full[W]);
      check("done_out_ovf", Out_Ovf, ovf);
      check("done_in_ready", In_ready, 0);
      if (chk_all || h == 0) begin
        check("done_busy", Busy, 1);
        check("done_add_idle", {nib(Add_A), nib(Add_B), 3'b000, Add_Ci}, 0);
      end
      if (h < hold) begin
        In_valid = 1'($urandom);
        In_A     = to_asc(W'($urandom));
        @(negedge Clk);
      end
    end
    Out_ready = 1'b1;
    In_valid  = 1'b0;
    @(negedge Clk);
    Out_ready = 1'b0;
    check("post_out_valid", Out_valid, 0);
    check("post_in_ready", In_ready, 1);
    check("post_busy", Busy, 0);
  endtask

  initial begin
    Rst_n     = 1'b0;
    In_valid  = 1'b0;
    In_A      = '0;
    In_B      = '0;
    In_Ci     = 1'b0;
    Out_ready = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("rst_out_valid", Out_valid, 0);
    check("rst_busy", Busy, 0);
    check("rst_out_s", from_asc(Out_S), 0);
    check("rst_co_ovf", {Out_Co, Out_Ovf}, 0);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rst_in_ready", In_ready, 1);

    run_op(16'h0001, 16'hFFFF, 1'b0, 0, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b1);
    run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b1);
    run_op(16'hA5C3, 16'h3C5A, 1'b1, 10, 1'b1);

    // Reset in the second RUN cycle.
    In_valid = 1'b1;
    In_A     = to_asc(16'hFFFF);
    In_B     = to_asc(16'hFFFF);
    In_Ci    = 1'b1;
    @(negedge Clk);
    In_valid = 1'b0;
    @(negedge Clk);
    check("mid_busy_before_rst", Busy, 1);
    Rst_n = 1'b0;
    #1;
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_out_valid", Out_valid, 0);
    check("mid_rst_out_s", from_asc(Out_S), 0);
    check("mid_rst_co_ovf", {Out_Co, Out_Ovf}, 0);
    check("mid_rst_add", {nib(Add_A), nib(Add_B), 3'b000, Add_Ci}, 0);
    #2;
    Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("after_rst_in_ready", In_ready, 1);
      check("after_rst_out_valid", Out_valid, 0);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b1);

    for (int t = 0; t < 25; t++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checked", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst_n  input  1  reset; asynchronous, active-low.
REQ-004 In_valid  input  1  operand set offered.
REQ-005 In_ready  output  1  block accepts an operand set this cycle.
REQ-006 In_A  input  [0:W-1]  operand A; index 0 = LSB.
REQ-007 In_B  input  [0:W-1]  operand B; index 0 = LSB.
REQ-008 In_Ci  input  1  carry-in for nibble 0.
REQ-009 Add_A  output  [0:3]  nibble of A driven to the external 4-bit adder; index 0 = LSB.
REQ-010 Add_B  output  [0:3]  nibble of B driven to the external 4-bit adder.
REQ-011 Add_Ci  output  1  carry driven to the external 4-bit adder.
REQ-012 Add_S  input  [0:3]  sum nibble returned from the adder, combinational from Add_A/Add_B/Add_Ci.
REQ-013 Add_Co  input  1  carry-out returned from the adder.
REQ-014 Out_valid  output  1  result held and valid.
REQ-015 Out_ready  input  1  consumer takes result.
REQ-016 Out_S  output  [0:W-1]  W-bit sum; index 0 = LSB.
REQ-017 Out_Co  output  1  unsigned carry-out of bit W-1.
REQ-018 Out_Ovf  output  1  two's-complement overflow.
REQ-019 Busy  output  1  high in RUN or DONE.

Function
REQ-020 FSM shall have exactly three states: IDLE, RUN, DONE.
REQ-021 In_ready shall be high only in IDLE; Out_valid shall be high only in DONE.
REQ-022 IDLE: when In_valid=1, the block shall register In_A, In_B and In_Ci (into the carry register), clear nibble counter k to 0 and go to RUN; otherwise it stays in IDLE.
REQ-023 RUN, combinational: Add_A = A_reg[4k..4k+3], Add_B = B_reg[4k..4k+3], Add_Ci = carry register.
REQ-024 RUN, each edge: the block shall write Add_S into sum_reg[4k..4k+3], load Add_Co into the carry register and increment k.
REQ-025 RUN shall go to DONE on the edge where k = NIBBLES-1 and shall never re-enter IDLE directly.
REQ-026 Latency: Out_valid shall rise exactly NIBBLES cycles after the accepting edge (4 for default); throughput is one operation per NIBBLES+2 cycles minimum.
REQ-027 Out_Co shall equal the last registered carry; Out_Ovf shall equal (A_reg[W-1] ~^ B_reg[W-1]) & (A_reg[W-1] ^ sum_reg[W-1]).
REQ-028 DONE shall hold Out_S, Out_Co and Out_Ovf stable until Out_valid & Out_ready, then go to IDLE; In_ready shall rise on the following cycle, with no same-cycle bypass.
REQ-029 Add_A, Add_B and Add_Ci shall be 0 outside RUN.
REQ-030 In_valid outside IDLE shall be ignored, and input changes during RUN shall not affect the result.
REQ-031 k shall be wide enough for NIBBLES-1 and shall never wrap within an operation.

Reset
REQ-032 On Rst_n low, at any time including mid-RUN and in DONE: the FSM shall go to IDLE; k, carry, A_reg, B_reg and sum_reg shall be cleared to 0; Out_valid=0, Busy=0, Out_S=0, Out_Co=0, Out_Ovf=0, and In_ready=1 once Rst_n is high.
REQ-033 An operation interrupted by reset shall be discarded and never reported.

Verification
REQ-034 0x0001 + 0xFFFF, Ci=0 -> Out_S=0x0000, Out_Co=1, Out_Ovf=0, Out_valid 4 cycles after accept.
REQ-035 0x7FFF + 0x0001, Ci=0 -> Out_S=0x8000, Out_Co=0, Out_Ovf=1; 0x8000 + 0x8000 -> 0x0000, Co=1, Ovf=1.
REQ-036 0x1234 + 0x4321, Ci=1 -> Out_S=0x5556, Out_Co=0; Add_A sequence 0x4,0x3,0x2,0x1 on successive RUN cycles.
REQ-037 Out_ready held low 10 cycles in DONE -> outputs stable and In_ready=0 throughout; a new In_valid pulse during that time is ignored.
REQ-038 Rst_n pulsed low during the second RUN cycle -> immediate IDLE, all outputs 0; the next operation 0x00FF + 0x0001 -> 0x0100 correct.
